avg_pool_2d_stream: RTL and testbench

//  Streaming 2D pooling engine; successor to the combinational avg_pool_2d.

---
 rtl/avg_pool_2d_stream.sv | 153 +++++++++++++++
 tb/tb_avg_pool_2d_stream.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_pool_2d_stream.sv
// Streaming KxK average/max pooling engine with partial-sum line buffer.
// Optional AVG_POOL_ROUND_EN: round-half-up averaging instead of truncation.
module avg_pool_2d_stream #(
  parameter int NBITS      = 8,
  parameter int NFMAPS     = 4,
  parameter int KER_SIZE_X = 2,
  parameter int KER_SIZE_Y = 2,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    pool_max,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NBITS*NFMAPS-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NBITS*NFMAPS-1:0] out_data,
  output logic                    out_last
);

  localparam int KN   = KER_SIZE_X * KER_SIZE_Y;
  localparam int S    = $clog2(KN);
  localparam int ACCW = NBITS + S;
  localparam int NWIN = IMG_W / KER_SIZE_X;
  localparam int WXW  = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int KXS  = $clog2(KER_SIZE_X);
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] KXM  = CW'(KER_SIZE_X - 1);
  localparam logic [RW-1:0] KYM  = RW'(KER_SIZE_Y - 1);
  localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);

  if (NBITS < 1 || NFMAPS < 1 || KER_SIZE_X < 1 || KER_SIZE_Y < 1 ||
      (KER_SIZE_X & (KER_SIZE_X - 1)) != 0 ||
      (KER_SIZE_Y & (KER_SIZE_Y - 1)) != 0 ||
      IMG_W < KER_SIZE_X || IMG_H < KER_SIZE_Y ||
      (IMG_W % KER_SIZE_X) != 0 || (IMG_H % KER_SIZE_Y) != 0) begin : g_bad
    $error("avg_pool_2d_stream: illegal parameter combination");
  end

  logic                          r_out_valid;
  logic                          r_out_last;
  logic [NBITS*NFMAPS-1:0]       r_out_data;
  logic [CW-1:0]                 r_col;
  logic [RW-1:0]                 r_row;
  logic                          r_mode;
  logic [NFMAPS-1:0][ACCW-1:0]   r_lb [NWIN];

  logic                          w_hs;
  logic [WXW-1:0]                w_wx;
  logic                          w_first_px;
  logic                          w_done;
  logic                          w_mode;
  logic                          w_last;
  logic [NFMAPS-1:0][ACCW-1:0]   w_old;
  logic [NFMAPS-1:0][ACCW-1:0]   w_acc;
  logic [ACCW-1:0]               w_pix;
  logic [NBITS*NFMAPS-1:0]       w_res;
`ifdef AVG_POOL_ROUND_EN
  localparam logic [ACCW:0] RND  = (ACCW+1)'((1 << S) >> 1);
  localparam logic [ACCW:0] SATV = (ACCW+1)'((1 << NBITS) - 1);
  logic [ACCW:0]                 w_rnd;
`endif

  assign in_ready   = !r_out_valid | out_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;

  assign w_hs       = in_valid & in_ready;
  assign w_wx       = WXW'(r_col >> KXS);
  assign w_first_px = ((r_col & KXM) == '0) && ((r_row & KYM) == '0);
  assign w_done     = ((r_col & KXM) == KXM) && ((r_row & KYM) == KYM);
  assign w_last     = (r_col == CMAX) && (r_row == RMAX);
  // The mode of a frame is whatever pool_max says on its first pixel.
  assign w_mode     = (r_col == '0 && r_row == '0) ? pool_max : r_mode;

  // Per-channel accumulate/max against the line buffer, and window result.
  always_comb begin
    w_old = r_lb[w_wx];
    w_acc = '0;
    w_res = '0;
    w_pix = '0;
`ifdef AVG_POOL_ROUND_EN
    w_rnd = '0;
`endif
    for (int c = 0; c < NFMAPS; c++) begin
      w_pix = ACCW'(in_data[c*NBITS +: NBITS]);
      if (w_first_px)
        w_acc[c] = w_pix;
      else if (w_mode)
        w_acc[c] = (w_pix > w_old[c]) ? w_pix : w_old[c];
      else
        w_acc[c] = w_old[c] + w_pix;
      if (w_mode) begin
        w_res[c*NBITS +: NBITS] = w_acc[c][NBITS-1:0];
      end else begin
`ifdef AVG_POOL_ROUND_EN
        w_rnd = ({1'b0, w_acc[c]} + RND) >> S;
        if (w_rnd > SATV)
          w_rnd = SATV;
        w_res[c*NBITS +: NBITS] = w_rnd[NBITS-1:0];
`else
        w_res[c*NBITS +: NBITS] = NBITS'(w_acc[c] >> S);
`endif
      end
    end
  end

  // Raster position and per-frame mode, advanced on each accepted pixel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col  <= '0;
      r_row  <= '0;
      r_mode <= 1'b0;
    end else if (w_hs) begin
      r_mode <= w_mode;
      if (r_col == CMAX) begin
        r_col <= '0;
        r_row <= (r_row == RMAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Partial window sums; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_hs)
      r_lb[w_wx] <= w_acc;
  end

  // Single-entry output register; a new result may replace a draining one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_hs && w_done) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_last;
      r_out_data  <= w_res;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avg_pool_2d_stream.sv
// Scoreboard bench for avg_pool_2d_stream (2x2 kernel, 4x4 frame).
// Reference model pools whole windows from a stored frame image.
module tb_avg_pool_2d_stream;

  localparam int NB = 8;
  localparam int NF = 4;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = NB * NF;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          pool_max = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;

  always #5 clk = ~clk;

  avg_pool_2d_stream #(
    .NBITS(NB), .NFMAPS(NF), .KER_SIZE_X(2), .KER_SIZE_Y(2),
    .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk), .rstn(rstn), .pool_max(pool_max),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  int            errors = 0;
  int            checks = 0;
  logic [DW:0]   expq[$];
  logic [DW-1:0] img[H][W];
  int            mr = 0;
  int            mc = 0;
  bit            fmode = 1'b0;
  bit            hs_complete = 1'b0;
  bit            chk_lat = 1'b0;
  int            vprob = 100;
  int            rprob = 100;
  bit            stall_req = 1'b0;
  int            stall_cnt = 0;

  always @(posedge clk) chk_lat <= hs_complete;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] gen(input int kind, input int r,
                                        input int c);
    logic [DW-1:0] d;
    d = $urandom;
    case (kind)
      0: d = {NF{8'd10}};
      1: d[7:0] = 8'((r % 2) * 2 + (c % 2) + 1);
      2: d = '1;
      3: for (int ch = 0; ch < NF; ch++)
           d[ch*NB +: NB] = 8'((r * W + c) * 7 + ch);
      default: ;
    endcase
    return d;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d);
    int sum;
    int mx;
    int v;
    logic [DW-1:0] res;
    img[mr][mc] = d;
    if (mr == 0 && mc == 0) fmode = pool_max;
    if (mr % 2 == 1 && mc % 2 == 1) begin
      res = '0;
      for (int ch = 0; ch < NF; ch++) begin
        sum = 0;
        mx = 0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++) begin
            v = int'(img[mr-1+dy][mc-1+dx][ch*NB +: NB]);
            sum += v;
            if (v > mx) mx = v;
          end
        if (fmode) v = mx;
        else begin
`ifdef AVG_POOL_ROUND_EN
          v = (sum + 2) / 4;
          if (v > 255) v = 255;
`else
          v = sum / 4;
`endif
        end
        res[ch*NB +: NB] = 8'(v);
      end
      expq.push_back({(mr == H-1 && mc == W-1), res});
      hs_complete = 1'b1;
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  task automatic drive_ready();
    if (stall_req && out_valid && stall_cnt == 0) begin
      stall_cnt = 5;
      stall_req = 1'b0;
    end
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else begin
      out_ready = ($urandom_range(0, 99) < rprob);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      hs_complete = 1'b0;
      in_valid = 1'b0;
      drive_ready();
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rstn = 1'b0;
    hs_complete = 1'b0;
    stall_cnt = 0;
    expq.delete();
    mr = 0;
    mc = 0;
    repeat (n) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_data = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic send_pix(input logic [DW-1:0] d, input bit m,
                          input bit first);
    bit hs;
    int guard;
    hs = 1'b0;
    guard = 0;
    while (!hs) begin
      @(negedge clk);
      hs_complete = 1'b0;
      in_valid = ($urandom_range(0, 99) < vprob);
      in_data = d;
      pool_max = first ? m : 1'($urandom);
      drive_ready();
      #1;
      hs = in_valid && in_ready;
      if (hs) model_accept(d);
      guard++;
      if (guard > 500) begin
        errors++;
        $display("FAIL input_timeout: got no handshake expected one");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "input handshake timeout");
      end
    end
  endtask

  task automatic frame(input bit m, input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pix(gen(kind, r, c), m, (r == 0 && c == 0));
  endtask

  // Monitor: samples after the driver settles, well away from posedge.
  initial begin : monitor
    bit          prev_stall;
    logic [DW:0] prev;
    logic [DW:0] e;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        prev_stall = 1'b0;
      end else begin
        check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (chk_lat) check("latency", 64'(out_valid), 64'd1);
        if (prev_stall) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_data", 64'({out_last, out_data}), 64'(prev));
        end
        prev_stall = out_valid && !out_ready;
        prev = {out_last, out_data};
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0h expected none",
                     {out_last, out_data});
          end else begin
            e = expq.pop_front();
            check("out", 64'({out_last, out_data}), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    do_reset(6);
    frame(1'b0, 0);
    frame(1'b0, 1);
    frame(1'b1, 1);
    frame(1'b0, 2);
    frame(1'b1, 2);
    vprob = 80;
    rprob = 70;
    stall_req = 1'b1;
    frame(1'b0, 4);
    stall_req = 1'b1;
    frame(1'b1, 3);
    for (int i = 0; i < 6; i++)
      send_pix(gen(3, i / W, i % W), 1'b1, (i == 0));
    do_reset(3);
    frame(1'b0, 3);
    repeat (8) begin
      stall_req = 1'($urandom_range(0, 1));
      frame(1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end
    rprob = 100;
    stall_req = 1'b0;
    for (int i = 0; i < 50 && expq.size() > 0; i++) idle(1);
    idle(3);
    check("drain_empty", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
